// File: rtl/dec_scan_n.sv
// Registered N-to-2^N one-hot/one-cold decoder with a direct-select mode and a
// self-stepping scan mode whose per-line dwell time is programmable.
module dec_scan_n #(
  parameter int SEL_W      = 2,
  parameter int DWELL_W    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       s,
  input  logic                   load,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [(2**SEL_W)-1:0]  I,
  output logic [SEL_W-1:0]       idx,
  output logic                   wrap
);

  localparam int OUT_N = 2 ** SEL_W;
  localparam logic [OUT_N-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DIRECT,
    ST_SCAN
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] dwell_reg;
  logic [DWELL_W-1:0] cnt;
  logic               scan_hold;
  logic [SEL_W-1:0]   idx_nxt;

  assign idx_nxt = idx + SEL_W'(1);

  function automatic logic [OUT_N-1:0] line_of(input logic [SEL_W-1:0] k);
    logic [OUT_N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  // scan_hold remembers that the scan was merely paused by en=0 with mode
  // still 1, so re-enabling resumes rather than restarting at line 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      I         <= INACTIVE;
      idx       <= '0;
      wrap      <= 1'b0;
      dwell_reg <= '0;
      cnt       <= '0;
      scan_hold <= 1'b0;
    end else begin
      if (load)
        dwell_reg <= dwell;
      wrap <= 1'b0;
      if (!en) begin
        state <= ST_OFF;
        I     <= INACTIVE;
        if (!mode)
          scan_hold <= 1'b0;
      end else if (!mode) begin
        state     <= ST_DIRECT;
        I         <= line_of(s);
        idx       <= s;
        cnt       <= '0;
        scan_hold <= 1'b0;
      end else begin
        state     <= ST_SCAN;
        scan_hold <= 1'b1;
        if (state == ST_DIRECT || (state == ST_OFF && !scan_hold)) begin
          idx <= '0;
          cnt <= '0;
          I   <= line_of('0);
        end else if (state == ST_OFF) begin
          I <= line_of(idx);
        end else if (cnt >= dwell_reg) begin
          cnt  <= '0;
          idx  <= idx_nxt;
          I    <= line_of(idx_nxt);
          wrap <= (idx == SEL_W'(OUT_N - 1));
        end else begin
          cnt <= cnt + DWELL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dec_scan_n.sv
// Directed bench for dec_scan_n: a default 2-bit active-high instance and a
// 3-bit active-low instance sharing clock and reset.
module tb_dec_scan_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       en_a = 1'b0, mode_a = 1'b0, load_a = 1'b0;
  logic [1:0] s_a = '0;
  logic [7:0] dwell_a = '0;
  logic [3:0] i_a;
  logic [1:0] idx_a;
  logic       wrap_a;

  logic       en_b = 1'b0, mode_b = 1'b0, load_b = 1'b0;
  logic [2:0] s_b = '0;
  logic [7:0] dwell_b = '0;
  logic [7:0] i_b;
  logic [2:0] idx_b;
  logic       wrap_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_scan_n #(.SEL_W(2), .DWELL_W(8), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .s(s_a),
    .load(load_a), .dwell(dwell_a), .I(i_a), .idx(idx_a), .wrap(wrap_a)
  );

  dec_scan_n #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .s(s_b),
    .load(load_b), .dwell(dwell_b), .I(i_b), .idx(idx_b), .wrap(wrap_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (i_a !== 4'b0000 || idx_a !== 2'd0 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a I=%b idx=%0d wrap=%b required 0000/0/0", i_a, idx_a, wrap_a);
    end
    checks++;
    if (i_b !== 8'hFF || idx_b !== 3'd0 || wrap_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b I=%b idx=%0d wrap=%b required 11111111/0/0", i_b, idx_b, wrap_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (i_a !== 4'b0000 || i_b !== 8'hFF) begin
      errors++;
      $display("FAIL reset_release_off I_a=%b I_b=%b required 0000/11111111", i_a, i_b);
    end
  endtask

  task automatic test_direct();
    logic [3:0] exp_i [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    en_a = 1'b1;
    mode_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_a = 2'(k);
      step();
      checks++;
      if (i_a !== exp_i[k] || idx_a !== 2'(k) || wrap_a !== 1'b0) begin
        errors++;
        $display("FAIL direct s=%0d I=%b idx=%0d wrap=%b required %b/%0d/0",
                 k, i_a, idx_a, wrap_a, exp_i[k], k);
      end
    end
  endtask

  task automatic test_scan_dwell0();
    logic [3:0] exp_i [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                              4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       exp_w [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    load_a = 1'b1;
    dwell_a = 8'd0;
    step();
    load_a = 1'b0;
    mode_a = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (i_a !== exp_i[k] || wrap_a !== exp_w[k]) begin
        errors++;
        $display("FAIL scan_d0 cyc=%0d I=%b wrap=%b required %b/%b",
                 k, i_a, wrap_a, exp_i[k], exp_w[k]);
      end
    end
  endtask

  task automatic test_scan_dwell2();
    logic [3:0] exp_i [13] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                               4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000,
                               4'b0001};
    logic [3:0] exp_r [3] = '{4'b0010, 4'b0010, 4'b0100};
    mode_a = 1'b0;
    load_a = 1'b1;
    dwell_a = 8'd2;
    step();
    load_a = 1'b0;
    mode_a = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step();
      checks++;
      if (i_a !== exp_i[k] || wrap_a !== (k == 12)) begin
        errors++;
        $display("FAIL scan_d2 cyc=%0d I=%b wrap=%b required %b/%b",
                 k, i_a, wrap_a, exp_i[k], (k == 12));
      end
    end
    // line 0 counts 1,2 then line 1 at count 0, then count 1 -> pause there
    for (int k = 0; k < 4; k++) step();
    en_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (i_a !== 4'b0000 || idx_a !== 2'd1 || wrap_a !== 1'b0) begin
        errors++;
        $display("FAIL scan_pause cyc=%0d I=%b idx=%0d wrap=%b required 0000/1/0",
                 k, i_a, idx_a, wrap_a);
      end
    end
    en_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (i_a !== exp_r[k]) begin
        errors++;
        $display("FAIL scan_resume cyc=%0d I=%b required %b", k, i_a, exp_r[k]);
      end
    end
  endtask

  task automatic test_reload();
    logic [3:0] exp_i [9] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                              4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    mode_a = 1'b0;
    load_a = 1'b1;
    dwell_a = 8'd7;
    step();
    load_a = 1'b0;
    mode_a = 1'b1;
    for (int k = 0; k < 6; k++) step();
    load_a = 1'b1;
    dwell_a = 8'd3;
    step();
    load_a = 1'b0;
    checks++;
    if (i_a !== 4'b0001) begin
      errors++;
      $display("FAIL reload_edge I=%b required 0001", i_a);
    end
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (i_a !== exp_i[k] || wrap_a !== 1'b0) begin
        errors++;
        $display("FAIL reload cyc=%0d I=%b wrap=%b required %b/0", k, i_a, wrap_a, exp_i[k]);
      end
    end
    mode_a = 1'b0;
    s_a = 2'd2;
    step();
    checks++;
    if (i_a !== 4'b0100 || idx_a !== 2'd2 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL scan_to_direct I=%b idx=%0d wrap=%b required 0100/2/0", i_a, idx_a, wrap_a);
    end
  endtask

  task automatic test_active_low();
    en_b = 1'b1;
    mode_b = 1'b0;
    s_b = 3'd5;
    step();
    checks++;
    if (i_b !== 8'b11011111 || idx_b !== 3'd5) begin
      errors++;
      $display("FAIL active_low_s5 I=%b idx=%0d required 11011111/5", i_b, idx_b);
    end
    s_b = 3'd0;
    step();
    checks++;
    if (i_b !== 8'b11111110 || idx_b !== 3'd0) begin
      errors++;
      $display("FAIL active_low_s0 I=%b idx=%0d required 11111110/0", i_b, idx_b);
    end
    en_b = 1'b0;
    step();
    checks++;
    if (i_b !== 8'hFF || idx_b !== 3'd0) begin
      errors++;
      $display("FAIL active_low_off I=%b idx=%0d required 11111111/0", i_b, idx_b);
    end
    en_b = 1'b1;
    s_b = 3'd5;
  endtask

  task automatic test_reset_midscan();
    en_a = 1'b1;
    mode_a = 1'b1;
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (i_a !== 4'b0000 || idx_a !== 2'd0 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_a I=%b idx=%0d wrap=%b required 0000/0/0", i_a, idx_a, wrap_a);
    end
    checks++;
    if (i_b !== 8'hFF || idx_b !== 3'd0) begin
      errors++;
      $display("FAIL async_reset_b I=%b idx=%0d required 11111111/0", i_b, idx_b);
    end
    en_a = 1'b0;
    en_b = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (i_a !== 4'b0000 || idx_a !== 2'd0 || wrap_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_release cyc=%0d I=%b idx=%0d wrap=%b required 0000/0/0",
                 k, i_a, idx_a, wrap_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_dwell0();
    test_scan_dwell2();
    test_reload();
    test_active_low();
    test_reset_midscan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
